axil_reg_slice: RTL and testbench

AXIL_REG_SLICE -- requirements
Module: axil_reg_slice

---
 rtl/axil_pkg.sv | 21 ++
 rtl/axil_skid_buffer.sv | 68 ++++++
 rtl/axil_reg_slice.sv | 98 +++++++++
 tb/tb_axil_reg_slice.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and constants for the register slice and its skid buffers.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  localparam int PROT_W = 3;
  localparam int RESP_W = 2;

  // Bit positions of each channel inside the REG_EN slice-enable vector.
  localparam int REG_AW = 0;
  localparam int REG_W  = 1;
  localparam int REG_B  = 2;
  localparam int REG_AR = 3;
  localparam int REG_R  = 4;

endpackage

// File: rtl/axil_skid_buffer.sv
// Single-channel valid/ready slice: 2-entry skid buffer when REG=1, plain wires when REG=0.
module axil_skid_buffer
  import axil_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit REG   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);

  if (REG) begin : g_reg
    logic             r_out_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;
    logic             w_out_free;

    assign w_in_fire  = i_in_valid & r_in_ready;
    // Output register may take a new beat when empty or being accepted this cycle.
    assign w_out_free = !r_out_valid | i_out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; payload registers are reset too, so nothing stale is visible.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b0;
        r_out_data   <= '0;
        r_skid_data  <= '0;
      end else if (w_out_free) begin
        r_in_ready <= 1'b1;
        if (r_skid_valid) begin
          // FULL draining: skid entry moves forward; source is stalled this cycle.
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_skid_valid <= 1'b0;
        end else begin
          r_out_valid <= w_in_fire;
          if (w_in_fire) r_out_data <= i_in_data;
        end
      end else if (w_in_fire) begin
        // ONE with sink stalled: park the beat and drop ready from the next cycle.
        r_skid_valid <= 1'b1;
        r_skid_data  <= i_in_data;
        r_in_ready   <= 1'b0;
      end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
  end else begin : g_bypass
    assign o_in_ready  = i_out_ready;
    assign o_out_valid = i_in_valid;
    assign o_out_data  = i_in_data;
  end

endmodule

// File: rtl/axil_reg_slice.sv
// AXI4-Lite register slice: five independent per-channel skid buffers between master and slave.
module axil_reg_slice
  import axil_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [4:0] REG_EN = 5'b11111
) (
  input  logic                clk,
  input  logic                rst_n,
  // master side
  input  logic [ADDR_W-1:0]   m_awaddr,
  input  logic [PROT_W-1:0]   m_awprot,
  input  logic                m_awvalid,
  output logic                m_awready,
  input  logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_wvalid,
  output logic                m_wready,
  output logic [RESP_W-1:0]   m_bresp,
  output logic                m_bvalid,
  input  logic                m_bready,
  input  logic [ADDR_W-1:0]   m_araddr,
  input  logic [PROT_W-1:0]   m_arprot,
  input  logic                m_arvalid,
  output logic                m_arready,
  output logic [DATA_W-1:0]   m_rdata,
  output logic [RESP_W-1:0]   m_rresp,
  output logic                m_rvalid,
  input  logic                m_rready,
  // slave side
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [PROT_W-1:0]   s_awprot,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [RESP_W-1:0]   s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [PROT_W-1:0]   s_arprot,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [RESP_W-1:0]   s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready
);

  localparam int A_W = ADDR_W + PROT_W;
  localparam int W_W = DATA_W + DATA_W / 8;
  localparam int R_W = DATA_W + RESP_W;

  logic [A_W-1:0] w_aw_out;
  logic [W_W-1:0] w_w_out;
  logic [A_W-1:0] w_ar_out;
  logic [R_W-1:0] w_r_out;

  axil_skid_buffer #(.WIDTH(A_W), .REG(REG_EN[REG_AW])) u_aw (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(m_awvalid), .o_in_ready(m_awready), .i_in_data({m_awprot, m_awaddr}),
    .o_out_valid(s_awvalid), .i_out_ready(s_awready), .o_out_data(w_aw_out)
  );

  axil_skid_buffer #(.WIDTH(W_W), .REG(REG_EN[REG_W])) u_w (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(m_wvalid), .o_in_ready(m_wready), .i_in_data({m_wstrb, m_wdata}),
    .o_out_valid(s_wvalid), .i_out_ready(s_wready), .o_out_data(w_w_out)
  );

  // Response channels flow slave -> master.
  axil_skid_buffer #(.WIDTH(RESP_W), .REG(REG_EN[REG_B])) u_b (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(s_bvalid), .o_in_ready(s_bready), .i_in_data(s_bresp),
    .o_out_valid(m_bvalid), .i_out_ready(m_bready), .o_out_data(m_bresp)
  );

  axil_skid_buffer #(.WIDTH(A_W), .REG(REG_EN[REG_AR])) u_ar (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(m_arvalid), .o_in_ready(m_arready), .i_in_data({m_arprot, m_araddr}),
    .o_out_valid(s_arvalid), .i_out_ready(s_arready), .o_out_data(w_ar_out)
  );

  axil_skid_buffer #(.WIDTH(R_W), .REG(REG_EN[REG_R])) u_r (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(s_rvalid), .o_in_ready(s_rready), .i_in_data({s_rresp, s_rdata}),
    .o_out_valid(m_rvalid), .i_out_ready(m_rready), .o_out_data(w_r_out)
  );

  assign {s_awprot, s_awaddr} = w_aw_out;
  assign {s_wstrb, s_wdata}   = w_w_out;
  assign {s_arprot, s_araddr} = w_ar_out;
  assign {m_rresp, m_rdata}   = w_r_out;

endmodule

// File: tb/tb_axil_reg_slice.sv
// Directed and random bench for axil_reg_slice: per-channel scoreboard plus a bypass instance.
module tb_axil_reg_slice;
  import axil_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Bench-driven inputs, shared by both instances.
  logic [AW-1:0] m_awaddr = '0, m_araddr = '0;
  logic [2:0]    m_awprot = '0, m_arprot = '0;
  logic          m_awvalid = 0, m_wvalid = 0, m_bready = 0, m_arvalid = 0, m_rready = 0;
  logic [DW-1:0] m_wdata = '0, s_rdata = '0;
  logic [3:0]    m_wstrb = '0;
  logic          s_awready = 0, s_wready = 0, s_bvalid = 0, s_arready = 0, s_rvalid = 0;
  logic [1:0]    s_bresp = '0, s_rresp = '0;

  // Registered instance outputs.
  logic          d_m_awready, d_m_wready, d_m_bvalid, d_m_arready, d_m_rvalid;
  logic [1:0]    d_m_bresp, d_m_rresp;
  logic [DW-1:0] d_m_rdata, d_s_wdata;
  logic [AW-1:0] d_s_awaddr, d_s_araddr;
  logic [2:0]    d_s_awprot, d_s_arprot;
  logic [3:0]    d_s_wstrb;
  logic          d_s_awvalid, d_s_wvalid, d_s_bready, d_s_arvalid, d_s_rready;

  // Bypass instance outputs.
  logic          b_m_awready, b_m_wready, b_m_bvalid, b_m_arready, b_m_rvalid;
  logic [1:0]    b_m_bresp, b_m_rresp;
  logic [DW-1:0] b_m_rdata, b_s_wdata;
  logic [AW-1:0] b_s_awaddr, b_s_araddr;
  logic [2:0]    b_s_awprot, b_s_arprot;
  logic [3:0]    b_s_wstrb;
  logic          b_s_awvalid, b_s_wvalid, b_s_bready, b_s_arvalid, b_s_rready;

  axil_reg_slice #(.ADDR_W(AW), .DATA_W(DW), .REG_EN(5'b11111)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(d_m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(d_m_wready),
    .m_bresp(d_m_bresp), .m_bvalid(d_m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(d_m_arready),
    .m_rdata(d_m_rdata), .m_rresp(d_m_rresp), .m_rvalid(d_m_rvalid), .m_rready(m_rready),
    .s_awaddr(d_s_awaddr), .s_awprot(d_s_awprot), .s_awvalid(d_s_awvalid), .s_awready(s_awready),
    .s_wdata(d_s_wdata), .s_wstrb(d_s_wstrb), .s_wvalid(d_s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(d_s_bready),
    .s_araddr(d_s_araddr), .s_arprot(d_s_arprot), .s_arvalid(d_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(d_s_rready)
  );

  axil_reg_slice #(.ADDR_W(AW), .DATA_W(DW), .REG_EN(5'b00000)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(b_m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(b_m_wready),
    .m_bresp(b_m_bresp), .m_bvalid(b_m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(b_m_arready),
    .m_rdata(b_m_rdata), .m_rresp(b_m_rresp), .m_rvalid(b_m_rvalid), .m_rready(m_rready),
    .s_awaddr(b_s_awaddr), .s_awprot(b_s_awprot), .s_awvalid(b_s_awvalid), .s_awready(s_awready),
    .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wvalid(b_s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(b_s_bready),
    .s_araddr(b_s_araddr), .s_arprot(b_s_arprot), .s_arvalid(b_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(b_s_rready)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-channel view of the registered instance: 0 AW, 1 W, 2 B, 3 AR, 4 R.
  logic [4:0]  src_v, src_r, snk_v, snk_r;
  logic [63:0] src_d [5];
  logic [63:0] snk_d [5];
  string       ch_name [5] = '{"aw", "w", "b", "ar", "r"};

  always_comb begin
    src_v = {s_rvalid, m_arvalid, s_bvalid, m_wvalid, m_awvalid};
    src_r = {d_s_rready, d_m_arready, d_s_bready, d_m_wready, d_m_awready};
    snk_v = {d_m_rvalid, d_s_arvalid, d_m_bvalid, d_s_wvalid, d_s_awvalid};
    snk_r = {m_rready, s_arready, m_bready, s_wready, s_awready};
    src_d[0] = 64'({m_awprot, m_awaddr});
    src_d[1] = 64'({m_wstrb, m_wdata});
    src_d[2] = 64'(s_bresp);
    src_d[3] = 64'({m_arprot, m_araddr});
    src_d[4] = 64'({s_rresp, s_rdata});
    snk_d[0] = 64'({d_s_awprot, d_s_awaddr});
    snk_d[1] = 64'({d_s_wstrb, d_s_wdata});
    snk_d[2] = 64'(d_m_bresp);
    snk_d[3] = 64'({d_s_arprot, d_s_araddr});
    snk_d[4] = 64'({d_m_rresp, d_m_rdata});
  end

  // Scoreboard: source handshakes push, sink handshakes pop and compare.
  logic [63:0] sb_q [5][$];
  logic [4:0]  prev_stall = '0;
  logic [63:0] prev_d [5];
  logic [63:0] exp_beat;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 5; c++) sb_q[c].delete();
      prev_stall = '0;
    end else begin
      for (int c = 0; c < 5; c++) begin
        if (prev_stall[c])
          check($sformatf("hold_%s", ch_name[c]), {snk_v[c], snk_d[c]}, {1'b1, prev_d[c]});
        if (snk_v[c] && snk_r[c]) begin
          n_vec++;
          assert (sb_q[c].size() != 0) else begin
            n_mis++;
            $error("FAIL sb_%s_extra: observed beat %0h expected none", ch_name[c], snk_d[c]);
          end
          if (sb_q[c].size() != 0) begin
            exp_beat = sb_q[c].pop_front();
            check($sformatf("sb_%s", ch_name[c]), 128'(snk_d[c]), 128'(exp_beat));
          end
        end
        if (src_v[c] && src_r[c]) sb_q[c].push_back(src_d[c]);
        prev_stall[c] = snk_v[c] & !snk_r[c];
        prev_d[c]     = snk_d[c];
      end
    end
  end

  logic [4:0] hold;

  initial begin
    // Reset state.
    #12;
    check("rst_valid", 128'({d_s_awvalid, d_s_wvalid, d_m_bvalid, d_s_arvalid, d_m_rvalid}), '0);
    check("rst_ready", 128'({d_m_awready, d_m_wready, d_s_bready, d_m_arready, d_s_rready}), '0);
    check("rst_payload", {d_s_awaddr, d_s_wdata, d_s_araddr, d_m_rdata}, '0);
    check("rst_side", 128'({d_s_awprot, d_s_wstrb, d_m_bresp, d_s_arprot, d_m_rresp}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready_rise", 128'({d_m_awready, d_m_wready, d_s_bready, d_m_arready, d_s_rready}),
          128'(5'b11111));

    // Single write.
    s_awready = 1; s_wready = 1; m_bready = 1; s_arready = 1; m_rready = 1;
    m_awvalid = 1; m_awaddr = 32'h0000_1000; m_awprot = 3'd0;
    m_wvalid = 1; m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hF;
    tick();
    m_awvalid = 0; m_wvalid = 0;
    check("wr_aw", 128'({d_s_awvalid, d_s_awprot, d_s_awaddr}), 128'({1'b1, 3'd0, 32'h0000_1000}));
    check("wr_w", 128'({d_s_wvalid, d_s_wstrb, d_s_wdata}), 128'({1'b1, 4'hF, 32'hDEAD_BEEF}));
    s_bvalid = 1; s_bresp = OKAY;
    tick();
    s_bvalid = 0;
    check("wr_b", 128'({d_m_bvalid, d_m_bresp}), 128'({1'b1, OKAY}));
    check("wr_aw_gone", 128'({d_s_awvalid, d_s_wvalid}), '0);
    tick();
    check("wr_b_gone", 128'(d_m_bvalid), '0);

    // Streaming reads: one beat out per cycle, one cycle behind.
    for (int i = 0; i < 16; i++) begin
      m_arvalid = 1; m_araddr = 32'(4 * i); m_arprot = 3'd0;
      tick();
      check($sformatf("rd_stream_%0d", i), 128'({d_s_arvalid, d_m_arready, d_s_araddr}),
            128'({1'b1, 1'b1, 32'(4 * i)}));
    end
    m_arvalid = 0;
    tick();
    check("rd_stream_end", 128'(d_s_arvalid), '0);

    // R backpressure: master stalls for five edges while the slave streams 1,2,3.
    m_rready = 0; s_rvalid = 1; s_rresp = OKAY; s_rdata = 32'h1;
    tick();
    s_rdata = 32'h2;
    tick();
    check("bp_ready_drop", 128'({d_s_rready, d_m_rvalid, d_m_rdata}), 128'({1'b0, 1'b1, 32'h1}));
    s_rdata = 32'h3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold_%0d", i), 128'({d_s_rready, d_m_rvalid, d_m_rdata}),
            128'({1'b0, 1'b1, 32'h1}));
    end
    m_rready = 1;
    tick();
    check("bp_rel_2", 128'({d_s_rready, d_m_rvalid, d_m_rdata}), 128'({1'b1, 1'b1, 32'h2}));
    tick();
    s_rvalid = 0;
    check("bp_rel_3", 128'({d_m_rvalid, d_m_rdata}), 128'({1'b1, 32'h3}));
    tick();
    check("bp_empty", 128'(d_m_rvalid), '0);

    // Reset while the AR slice is FULL.
    s_arready = 0; m_arvalid = 1; m_araddr = 32'hA0;
    tick();
    m_araddr = 32'hA4;
    tick();
    check("ar_full", 128'({d_m_arready, d_s_arvalid, d_s_araddr}), 128'({1'b0, 1'b1, 32'hA0}));
    #2;
    rst_n = 0; m_arvalid = 0;
    #1;
    check("ar_rst_async", 128'({d_s_arvalid, d_m_arready, d_s_araddr}), '0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    tick();
    check("ar_rst_ready", 128'(d_m_arready), 128'(1'b1));
    s_arready = 1; m_arvalid = 1; m_araddr = 32'hB0;
    tick();
    m_arvalid = 0;
    check("ar_after_rst", 128'({d_s_arvalid, d_s_araddr}), 128'({1'b1, 32'hB0}));
    tick();

    // Random traffic on every channel; sources respect valid/payload hold.
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      hold = src_v & ~src_r;
      @(posedge clk);
      #1;
      if (!hold[0]) begin m_awvalid = 1'($urandom); m_awaddr = $urandom; m_awprot = 3'($urandom); end
      if (!hold[1]) begin m_wvalid = 1'($urandom); m_wdata = $urandom; m_wstrb = 4'($urandom); end
      if (!hold[2]) begin s_bvalid = 1'($urandom); s_bresp = 2'($urandom); end
      if (!hold[3]) begin m_arvalid = 1'($urandom); m_araddr = $urandom; m_arprot = 3'($urandom); end
      if (!hold[4]) begin s_rvalid = 1'($urandom); s_rdata = $urandom; s_rresp = 2'($urandom); end
      s_awready = 1'($urandom); s_wready = 1'($urandom); m_bready = 1'($urandom);
      s_arready = 1'($urandom); m_rready = 1'($urandom);
      #1;
      check("byp_aw", 128'({b_s_awvalid, b_s_awprot, b_s_awaddr, b_m_awready}),
            128'({m_awvalid, m_awprot, m_awaddr, s_awready}));
      check("byp_w", 128'({b_s_wvalid, b_s_wstrb, b_s_wdata, b_m_wready}),
            128'({m_wvalid, m_wstrb, m_wdata, s_wready}));
      check("byp_b", 128'({b_m_bvalid, b_m_bresp, b_s_bready}), 128'({s_bvalid, s_bresp, m_bready}));
      check("byp_ar", 128'({b_s_arvalid, b_s_arprot, b_s_araddr, b_m_arready}),
            128'({m_arvalid, m_arprot, m_araddr, s_arready}));
      check("byp_r", 128'({b_m_rvalid, b_m_rresp, b_m_rdata, b_s_rready}),
            128'({s_rvalid, s_rresp, s_rdata, m_rready}));
    end

    // Drain: sinks always ready, sources stop once their pending beat is taken.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      hold = src_v & ~src_r;
      @(posedge clk);
      #1;
      if (!hold[0]) m_awvalid = 0;
      if (!hold[1]) m_wvalid = 0;
      if (!hold[2]) s_bvalid = 0;
      if (!hold[3]) m_arvalid = 0;
      if (!hold[4]) s_rvalid = 0;
      s_awready = 1; s_wready = 1; m_bready = 1; s_arready = 1; m_rready = 1;
    end
    for (int c = 0; c < 5; c++)
      check($sformatf("drain_%s", ch_name[c]), 128'(sb_q[c].size()), '0);
    check("drain_valid", 128'(snk_v), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
